pair_detect_arbiter: RTL
========================

Name: pair_detect_arbiter

Overview:
- Shares one pair-of-equal-bits detection engine (non-overlapping "11"/"00" detector) among NCH independent serial bit streams.
- Keeps a per-channel detector context.
- A round-robin arbiter grants one channel per clock; the engine advances that channel's context and emits a tagged match event.
- Sits between the serial front-ends and the event/statistics logic.

Parameters:
NCH, 4, number of requesting serial channels (2..16)
CW, 2, channel index width, equals ceil(log2(NCH))
CNTW, 8, width of the saturating total-match counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = arbitration runs; 0 = no grants, all state holds
in_valid  in  NCH  per-channel: bit available on in_bit[i]
in_bit  in  NCH  per-channel serial data bit
in_ready  out  NCH  one-hot grant (combinational); transfer on channel i = in_valid[i] & in_ready[i]
ctx_clear  in  NCH  per-channel synchronous context clear
match_valid  out  1  one-cycle pulse: pair detected
match_ch  out  CW  channel index of the match
match_kind  out  1  1 = pair of ones, 0 = pair of zeros
match_total  out  CNTW  saturating count of all matches

Behaviour:
- Reset (synchronous, active-high) sets:
  - all contexts to IDLE
  - rr pointer to 0
  - match_valid, match_ch, match_kind, match_total to 0
- Reset dominates every other input in the same cycle.
- Reset mid-stream discards all partial pairs.
- Per-channel context: 2-bit state.
  - IDLE: no pending bit.
  - ONE: last bit 1.
  - ZERO: last bit 0.
- Engine transitions for the granted channel with bit b:
  - IDLE: b=1 -> ONE; b=0 -> ZERO; no match.
  - ONE: b=1 -> IDLE, match kind 1; b=0 -> ZERO, no match.
  - ZERO: b=0 -> IDLE, match kind 0; b=1 -> ONE, no match.
  - Unused encoding -> IDLE, no match.
- Detection is non-overlapping: "111" yields one match; "1111" yields two.
- Arbitration (combinational):
  - Eligible[i] = in_valid[i] & ~ctx_clear[i] & enable.
  - Grant the first eligible index searching rr, rr+1, ... NCH-1, 0, ... rr-1.
  - At most one bit of in_ready is high; in_ready is all-zero when nothing is eligible.
  - in_ready may depend on in_valid; requesters must not make in_valid depend on in_ready.
- rr update at the clock edge:
  - On a grant to channel g: rr <= (g+1) mod NCH.
  - Otherwise rr holds.
  - This guarantees each continuously valid channel is served at least once every NCH cycles.
- Latency:
  - A transfer in cycle t updates the context at edge t.
  - If the transfer completes a pair, match_valid=1 with match_ch/match_kind in cycle t+1 (registered).
  - Otherwise match_valid=0 in cycle t+1.
  - match_ch/match_kind hold their last values when match_valid=0.
- Throughput: one bit per clock aggregate; back-to-back matches on different channels give consecutive match_valid pulses.
- match_total:
  - Increments with each match_valid assertion, i.e. at the same edge as the registered match.
  - Saturates at 2^CNTW-1 and never wraps.
- ctx_clear[i]:
  - Forces context i to IDLE at the next edge.
  - Masks the channel from arbitration that cycle, so no transfer and no match occur.
  - Clears on several channels in one cycle are independent.
  - Other channels are unaffected.
- enable=0:
  - in_ready=0 and contexts hold.
  - rr holds; match_total holds.
  - match_valid is 0 in the following cycle.
  - ctx_clear still acts.
- A channel whose in_valid drops keeps its context indefinitely; pairs span arbitrarily long gaps.

Test Plan:
- Reset then single channel: NCH=4, only ch2 valid, bits 1,1,0,0,1 on consecutive grants -> match_valid pulses after the 2nd bit (ch=2, kind=1) and after the 4th bit (ch=2, kind=0); match_total=2; ch2 ends in ONE.
- Round-robin fairness: all four channels valid for 8 cycles -> grant order ch0,1,2,3,0,1,2,3; with every channel fed 1 each time, four matches in cycles 5..8 tagged ch0..ch3, match_total=4.
- Interleaving isolation: ch0 fed 1, ch1 fed 0, ch0 fed 1 (alternating grants) -> exactly one match, ch=0 kind=1; ch1 left in ZERO.
- Clear collision: ch1 in ONE, in_valid[1]=1 with in_bit=1 and ctx_clear[1]=1 in the same cycle -> in_ready[1]=0, no match, ch1 IDLE; the next bit 1 yields no match.
- Enable gating and saturation: with CNTW=2 drive 5 matches -> match_total 1,2,3,3,3; enable=0 with all valid -> in_ready=0, no state change.
- Reset mid-pair: ch3 in ZERO, reset asserted 1 cycle with valid bit 0 presented -> no match, all outputs 0, rr=0; the subsequent bit 0 yields no match.

Source files
------------

// File: rtl/pair_detect_arbiter.sv
// -----------------------------------------------------------------------------
// pair_detect_arbiter
//
// One "pair of equal bits" detection engine shared by NCH serial bit streams.
// Each channel keeps its own 2-bit detector context (IDLE / ONE / ZERO). Each
// clock a round-robin arbiter grants at most one eligible channel. The engine
// advances that channel's context with the offered bit. When the bit completes
// a non-overlapping "11" or "00" pair, the engine emits a registered match
// event tagged with the channel index and the pair kind.
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   enable       1 = arbitration runs, 0 = no grants and all state holds
//                (ctx_clear still acts)
//   in_valid     per-channel: a bit is offered on in_bit[i]
//   in_bit       per-channel serial data bit
//   in_ready     one-hot combinational grant; a transfer happens on channel i
//                when in_valid[i] & in_ready[i]
//   ctx_clear    per-channel synchronous context clear; also masks the
//                channel from arbitration in that cycle
//   match_valid  one-cycle pulse, the cycle after the pair-completing transfer
//   match_ch     channel index of the last match (holds between matches)
//   match_kind   1 = pair of ones, 0 = pair of zeros (holds between matches)
//   match_total  saturating count of all matches
// -----------------------------------------------------------------------------
module pair_detect_arbiter #(
  parameter int NCH  = 4,
  parameter int CW   = 2,
  parameter int CNTW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [NCH-1:0]  in_valid,
  input  logic [NCH-1:0]  in_bit,
  output logic [NCH-1:0]  in_ready,
  input  logic [NCH-1:0]  ctx_clear,
  output logic            match_valid,
  output logic [CW-1:0]   match_ch,
  output logic            match_kind,
  output logic [CNTW-1:0] match_total
);

  // Detector context encoding. Encoding 2'b11 is never written. If it is
  // ever seen, the engine falls back to IDLE.
  typedef enum logic [1:0] {
    CTX_IDLE = 2'b00,
    CTX_ONE  = 2'b01,
    CTX_ZERO = 2'b10,
    CTX_BAD  = 2'b11
  } ctx_t;

  localparam logic [CNTW-1:0] TOTAL_MAX = {CNTW{1'b1}};
  localparam logic [CW:0]     NCH_W     = (CW+1)'(NCH);
  localparam logic [CW-1:0]   LAST_CH   = CW'(NCH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NCH-1:0][1:0] ctx_reg;
  logic [NCH-1:0][1:0] ctx_next;
  logic [CW-1:0]       rr_reg;
  logic                match_valid_reg;
  logic [CW-1:0]       match_ch_reg;
  logic                match_kind_reg;
  logic [CNTW-1:0]     match_total_reg;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] eligible;
  logic           grant_any;
  logic [CW-1:0]  grant_idx;

  // A channel being cleared is masked out, so a clear never collides with a
  // transfer on the same channel.
  assign eligible = in_valid & ~ctx_clear & {NCH{enable}};

  // Scan rr, rr+1, ... with wrap-around and take the first eligible channel.
  // The sum uses one spare bit, so the wrap works for any NCH up to 2^CW.
  always_comb begin
    logic [CW:0]   scan_sum;
    logic [CW-1:0] scan_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_sum = {1'b0, rr_reg} + (CW+1)'(k);
      if (scan_sum >= NCH_W) begin
        scan_sum = scan_sum - NCH_W;
      end
      scan_idx = scan_sum[CW-1:0];
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // The grant is one-hot. It is driven only from the arbitration result.
  always_comb begin
    in_ready = '0;
    if (grant_any) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared detection engine: operates on the granted channel only
  // ---------------------------------------------------------------------------
  ctx_t engine_cur;
  logic engine_bit;
  ctx_t engine_step;
  logic engine_hit;

  assign engine_cur = ctx_t'(ctx_reg[grant_idx]);
  assign engine_bit = in_bit[grant_idx];

  always_comb begin
    engine_step = CTX_IDLE;
    engine_hit  = 1'b0;
    case (engine_cur)
      CTX_IDLE: begin
        engine_step = engine_bit ? CTX_ONE : CTX_ZERO;
      end
      CTX_ONE: begin
        if (engine_bit) begin
          // Completed "11". The pair is consumed, so detection never overlaps.
          engine_step = CTX_IDLE;
          engine_hit  = 1'b1;
        end else begin
          engine_step = CTX_ZERO;
        end
      end
      CTX_ZERO: begin
        if (!engine_bit) begin
          engine_step = CTX_IDLE;
          engine_hit  = 1'b1;
        end else begin
          engine_step = CTX_ONE;
        end
      end
      default: begin
        engine_step = CTX_IDLE;
        engine_hit  = 1'b0;
      end
    endcase
  end

  logic match_fire;
  assign match_fire = grant_any & engine_hit;

  // ---------------------------------------------------------------------------
  // Per-channel context next-state.
  // A clear wins over everything except reset. A granted channel takes the
  // engine result. Every other channel holds, however long its gap lasts.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ctx
      assign ctx_next[gi] = ctx_clear[gi] ? CTX_IDLE
                          : (in_ready[gi] ? engine_step : ctx_reg[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      ctx_reg         <= '0;
      rr_reg          <= '0;
      match_valid_reg <= 1'b0;
      match_ch_reg    <= '0;
      match_kind_reg  <= 1'b0;
      match_total_reg <= '0;
    end else begin
      ctx_reg         <= ctx_next;
      match_valid_reg <= match_fire;
      if (grant_any) begin
        // Start the next scan just after the channel that was served.
        rr_reg <= (grant_idx == LAST_CH) ? '0 : grant_idx + CW'(1);
      end
      if (match_fire) begin
        match_ch_reg   <= grant_idx;
        match_kind_reg <= engine_bit;
        if (match_total_reg != TOTAL_MAX) begin
          match_total_reg <= match_total_reg + CNTW'(1);
        end
      end
    end
  end

  assign match_valid = match_valid_reg;
  assign match_ch    = match_ch_reg;
  assign match_kind  = match_kind_reg;
  assign match_total = match_total_reg;

endmodule
